// File: rtl/qos_req_shaper_if.sv
// -----------------------------------------------------------------------------
// qos_req_shaper_if
//
// Bundles the two handshakes of the QoS request shaper:
//   * descriptor push : pkt_valid / pkt_ready carrying pkt_size and pkt_prio
//   * arbiter request : req_valid / req_prio / req_size towards the arbiter,
//                       grant_valid back from the arbiter, grant_ack forward
//
// Modports
//   master : the surrounding logic (packet source plus arbiter); drives the
//            descriptor payload and the grant, observes ready/request/ack.
//   slave  : the shaper itself.
// -----------------------------------------------------------------------------
interface qos_req_shaper_if #(
    parameter int PRIO_WIDTH = 2,
    parameter int SIZE_WIDTH = 16
);
    // Descriptor push channel
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [SIZE_WIDTH-1:0] pkt_size;
    logic [PRIO_WIDTH-1:0] pkt_prio;

    // Arbiter request / grant channel
    logic                  req_valid;
    logic [PRIO_WIDTH-1:0] req_prio;
    logic [SIZE_WIDTH-1:0] req_size;
    logic                  grant_valid;
    logic                  grant_ack;

    modport master (
        output pkt_valid,
        output pkt_size,
        output pkt_prio,
        output grant_valid,
        input  pkt_ready,
        input  req_valid,
        input  req_prio,
        input  req_size,
        input  grant_ack
    );

    modport slave (
        input  pkt_valid,
        input  pkt_size,
        input  pkt_prio,
        input  grant_valid,
        output pkt_ready,
        output req_valid,
        output req_prio,
        output req_size,
        output grant_ack
    );
endinterface

// File: rtl/qos_req_shaper.sv
// -----------------------------------------------------------------------------
// qos_req_shaper
//
// Token-bucket shaper in front of a QoS arbiter. Packet descriptors (size in
// tokens plus priority) are queued in a small FIFO. The descriptor at the head
// is offered to the arbiter only once the bucket holds at least its size; a
// grant removes the descriptor, deducts its size from the bucket and is
// acknowledged for exactly one cycle. A request that waits too long for a grant
// has its priority escalated to all-ones.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : descriptor push and arbiter request/grant handshakes
//   cfg_rate            : tokens added to the bucket every cycle
//   cfg_burst           : bucket capacity
//   token_count         : current bucket level
//   fifo_level          : number of queued descriptors
//   rate_stall          : head descriptor is waiting for tokens
//   err_spurious_grant  : sticky, a grant arrived while no request was pending
// -----------------------------------------------------------------------------
module qos_req_shaper #(
    parameter int DEPTH       = 8,   // power of two, >= 2
    parameter int PRIO_WIDTH  = 2,
    parameter int SIZE_WIDTH  = 16,
    parameter int TOKEN_WIDTH = 32,
    parameter int AGE_LIMIT   = 64   // REQ cycles before priority escalation
) (
    input  logic                         clk,
    input  logic                         rst_n,
    qos_req_shaper_if.slave              bus,
    input  logic [TOKEN_WIDTH-1:0]       cfg_rate,
    input  logic [TOKEN_WIDTH-1:0]       cfg_burst,
    output logic [TOKEN_WIDTH-1:0]       token_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         rate_stall,
    output logic                         err_spurious_grant
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int LVL_WIDTH = $clog2(DEPTH + 1);
    localparam int AGE_WIDTH = $clog2(AGE_LIMIT + 1);
    // Common width for comparing the bucket against a descriptor size.
    localparam int CMP_WIDTH = (SIZE_WIDTH > TOKEN_WIDTH) ? SIZE_WIDTH : TOKEN_WIDTH;

    localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(DEPTH);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX  = AGE_WIDTH'(AGE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TOKEN,
        REQ,
        ACK
    } state_t;

    typedef struct packed {
        logic [PRIO_WIDTH-1:0] prio;
        logic [SIZE_WIDTH-1:0] size;
    } desc_t;

    // ---------------------------------------------------------------------
    // Descriptor FIFO
    // ---------------------------------------------------------------------
    desc_t                mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [LVL_WIDTH-1:0] level;
    logic                 ready_en;   // low in reset, high from the first edge after
    logic                 pkt_ready;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    desc_t                head;

    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    // Ready comes from the registered level only, so a full FIFO refuses a
    // push even when a pop happens in the same cycle.
    assign pkt_ready = ready_en && !full;
    assign push      = bus.pkt_valid && pkt_ready;
    assign head      = mem[rd_ptr];

    // NOTE: the storage array carries no reset; occupancy is tracked by the
    // pointers and level, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{prio: bus.pkt_prio, size: bus.pkt_size};
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_WIDTH'(1);
                2'b01:   level <= level - LVL_WIDTH'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Token bucket
    // ---------------------------------------------------------------------
    logic [TOKEN_WIDTH-1:0] tokens;
    logic [TOKEN_WIDTH-1:0] tokens_next;
    logic [TOKEN_WIDTH:0]   tok_sum;
    logic [TOKEN_WIDTH:0]   tok_deduct;
    logic [TOKEN_WIDTH:0]   tok_net;
    logic                   head_eligible;

    // A zero-size head is always eligible since tokens >= 0.
    assign head_eligible = (CMP_WIDTH'(tokens) >= CMP_WIDTH'(head.size));

    // Refill and deduction are applied together in one extra bit of headroom,
    // floored at zero (cfg_burst may have been lowered under an in-flight
    // size) and then clamped to the bucket cap.
    always_comb begin
        tok_sum    = {1'b0, tokens} + {1'b0, cfg_rate};
        tok_deduct = pop ? (TOKEN_WIDTH + 1)'(head.size) : '0;
        tok_net    = (tok_sum > tok_deduct) ? (tok_sum - tok_deduct) : '0;
        if (tok_net > {1'b0, cfg_burst}) begin
            tokens_next = cfg_burst;
        end else begin
            tokens_next = tok_net[TOKEN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tokens <= '0;
        end else begin
            tokens <= tokens_next;
        end
    end

    // ---------------------------------------------------------------------
    // Request FSM
    // ---------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   req_valid;
    logic   grant_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        grant_ack  = 1'b0;
        rate_stall = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = head_eligible ? REQ : WAIT_TOKEN;
                end
            end
            WAIT_TOKEN: begin
                // An oversized head (size > cfg_burst) parks here for good.
                rate_stall = 1'b1;
                if (head_eligible) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.grant_valid) begin
                    pop        = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                // The ACK cycle doubles as the mandatory request gap.
                grant_ack  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Request aging: 0 on the first REQ cycle, +1 per further REQ cycle,
    // saturating; cleared whenever the FSM is not staying in REQ.
    // ---------------------------------------------------------------------
    logic [AGE_WIDTH-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (state == REQ && state_next == REQ) begin
            if (age != AGE_MAX) begin
                age <= age + AGE_WIDTH'(1);
            end
        end else begin
            age <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Spurious grant flag: sticky until reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_spurious_grant <= 1'b0;
        end else if (bus.grant_valid && state != REQ) begin
            err_spurious_grant <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // Head fields are stable while in REQ since the FIFO only pops on grant;
    // they are forced to zero outside REQ so the arbiter never sees stale data.
    assign bus.pkt_ready = pkt_ready;
    assign bus.req_valid = req_valid;
    assign bus.grant_ack = grant_ack;
    assign bus.req_size  = req_valid ? head.size : '0;
    assign bus.req_prio  = !req_valid       ? '0 :
                           (age == AGE_MAX) ? '1 : head.prio;

    assign token_count = tokens;
    assign fifo_level  = level;

endmodule

// File: tb/tb_qos_req_shaper.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_qos_req_shaper
//
// Directed bench for qos_req_shaper. Descriptors are pushed into a scoreboard
// queue as they are accepted and compared against the request fields when the
// DUT raises req_valid. The bucket level is tracked by an independent model
// stepped once per clock edge.
// -----------------------------------------------------------------------------
module tb_qos_req_shaper;

    localparam int DEPTH       = 8;
    localparam int PRIO_WIDTH  = 2;
    localparam int SIZE_WIDTH  = 16;
    localparam int TOKEN_WIDTH = 32;
    localparam int AGE_LIMIT   = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [TOKEN_WIDTH-1:0]      cfg_rate;
    logic [TOKEN_WIDTH-1:0]      cfg_burst;
    logic [TOKEN_WIDTH-1:0]      token_count;
    logic [$clog2(DEPTH+1)-1:0]  fifo_level;
    logic                        rate_stall;
    logic                        err_spurious_grant;

    always #5 clk = ~clk;

    qos_req_shaper_if #(.PRIO_WIDTH(PRIO_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) bus ();

    qos_req_shaper #(
        .DEPTH       (DEPTH),
        .PRIO_WIDTH  (PRIO_WIDTH),
        .SIZE_WIDTH  (SIZE_WIDTH),
        .TOKEN_WIDTH (TOKEN_WIDTH),
        .AGE_LIMIT   (AGE_LIMIT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (bus),
        .cfg_rate           (cfg_rate),
        .cfg_burst          (cfg_burst),
        .token_count        (token_count),
        .fifo_level         (fifo_level),
        .rate_stall         (rate_stall),
        .err_spurious_grant (err_spurious_grant)
    );

    typedef struct {
        logic [SIZE_WIDTH-1:0] size;
        logic [PRIO_WIDTH-1:0] prio;
    } exp_t;

    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    longint tok_m    = 0;   // bucket model
    longint deduct_pending = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: step the bucket model with the inputs seen at this edge,
    // then sample outputs 1ns after the edge.
    task automatic tick();
        longint nxt;
        longint rate;
        longint burst;
        rate  = cfg_rate;
        burst = cfg_burst;
        if (!rst_n) begin
            nxt = 0;
        end else begin
            nxt = tok_m + rate - deduct_pending;
            if (nxt < 0)     nxt = 0;
            if (nxt > burst) nxt = burst;
        end
        @(posedge clk);
        tok_m          = nxt;
        deduct_pending = 0;
        #1;
    endtask

    task automatic push_desc(input int size, input int prio);
        exp_t e;
        bus.pkt_valid = 1'b1;
        bus.pkt_size  = SIZE_WIDTH'(size);
        bus.pkt_prio  = PRIO_WIDTH'(prio);
        e.size = SIZE_WIDTH'(size);
        e.prio = PRIO_WIDTH'(prio);
        check("push_ready", bus.pkt_ready, 1);
        sb.push_back(e);
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    // Wait (bounded) for req_valid; on the first REQ cycle age is 0, so the
    // head fields must match the scoreboard front unmodified.
    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.req_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, bus.req_valid, 1);
        if (bus.req_valid && sb.size() != 0) begin
            check({tag, "_req_size"}, bus.req_size, sb[0].size);
            check({tag, "_req_prio"}, bus.req_prio, sb[0].prio);
        end
    endtask

    task automatic do_grant(input string tag);
        exp_t e;
        check({tag, "_pre_grant_req"}, bus.req_valid, 1);
        bus.grant_valid = 1'b1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            deduct_pending = e.size;
        end
        tick();
        bus.grant_valid = 1'b0;
        check({tag, "_ack"}, bus.grant_ack, 1);
        check({tag, "_ack_req_low"}, bus.req_valid, 0);
        check({tag, "_ack_tokens"}, token_count, tok_m);
        tick();
        check({tag, "_ack_one_cycle"}, bus.grant_ack, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int accepted;

        bus.pkt_valid   = 1'b0;
        bus.pkt_size    = '0;
        bus.pkt_prio    = '0;
        bus.grant_valid = 1'b0;
        cfg_rate        = '0;
        cfg_burst       = '0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #2;

        // ---- reset state ----
        check("rst_req_valid",  bus.req_valid, 0);
        check("rst_grant_ack",  bus.grant_ack, 0);
        check("rst_rate_stall", rate_stall, 0);
        check("rst_err",        err_spurious_grant, 0);
        check("rst_tokens",     token_count, 0);
        check("rst_level",      fifo_level, 0);
        check("rst_pkt_ready",  bus.pkt_ready, 0);
        tick();
        tick();
        check("rst_pkt_ready_held", bus.pkt_ready, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_pkt_ready", bus.pkt_ready, 1);
        check("post_rst_tokens", token_count, 0);

        // ---- rate 10, burst 100, size 40: WAIT_TOKEN until tokens = 40 ----
        cfg_rate  = 10;
        cfg_burst = 100;
        push_desc(40, 2);
        check("t1_level", fifo_level, 1);
        check("t1_tokens_first", token_count, 10);
        check("t1_idle_no_stall", rate_stall, 0);
        tick();
        for (int g = 0; g < 10 && tok_m < 40; g++) begin
            check("t1_stall", rate_stall, 1);
            check("t1_no_req", bus.req_valid, 0);
            check("t1_tokens", token_count, tok_m);
            tick();
        end
        check("t1_tokens_40", token_count, 40);
        check("t1_stall_at_40", rate_stall, 1);
        check("t1_no_req_at_40", bus.req_valid, 0);
        tick();
        wait_req("t1", 0);
        check("t1_tokens_req", token_count, 50);
        do_grant("t1");
        check("t1_level_empty", fifo_level, 0);

        // ---- rate 1000, burst 50: saturate; size 0 has two-cycle latency ----
        cfg_rate  = 1000;
        cfg_burst = 50;
        tick();
        check("t2_sat", token_count, 50);
        tick();
        check("t2_sat_held", token_count, 50);
        push_desc(0, 1);
        check("t2_no_req_n1", bus.req_valid, 0);
        tick();
        wait_req("t2", 0);
        do_grant("t2");
        check("t2_tokens_after", token_count, 50);

        // ---- fill FIFO with 9 attempts, no grants ----
        accepted = 0;
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            bus.pkt_valid = 1'b1;
            bus.pkt_size  = SIZE_WIDTH'(i + 1);
            bus.pkt_prio  = '0;
            if (bus.pkt_ready) begin
                e.size = SIZE_WIDTH'(i + 1);
                e.prio = '0;
                sb.push_back(e);
                accepted++;
            end
            tick();
        end
        bus.pkt_valid = 1'b0;
        check("t3_accepted", accepted, 8);
        check("t3_level_full", fifo_level, 8);
        check("t3_ready_full", bus.pkt_ready, 0);
        check("t3_req_valid", bus.req_valid, 1);
        check("t3_req_size", bus.req_size, sb[0].size);
        check("t3_prio_escalated", bus.req_prio, 3);
        do_grant("t3");
        check("t3_level_7", fifo_level, 7);
        check("t3_ready_back", bus.pkt_ready, 1);
        for (int k = 0; k < 7; k++) begin
            wait_req("t3_drain", 10);
            do_grant("t3_drain");
        end
        check("t3_drained", fifo_level, 0);

        // ---- aging with AGE_LIMIT = 4 ----
        push_desc(5, 1);
        wait_req("t4", 10);
        for (int k = 0; k < 4; k++) begin
            check("t4_prio_base", bus.req_prio, 1);
            tick();
        end
        check("t4_prio_esc", bus.req_prio, 3);
        check("t4_still_req", bus.req_valid, 1);
        do_grant("t4");
        push_desc(5, 2);
        wait_req("t4_next", 10);
        do_grant("t4_next");

        // ---- spurious grant in IDLE ----
        bus.grant_valid = 1'b1;
        tick();
        bus.grant_valid = 1'b0;
        check("t5_err_set", err_spurious_grant, 1);
        check("t5_tokens_unchanged", token_count, 50);
        check("t5_no_ack", bus.grant_ack, 0);
        check("t5_no_req", bus.req_valid, 0);
        tick();
        check("t5_err_sticky", err_spurious_grant, 1);

        // ---- reset mid-REQ ----
        push_desc(3, 0);
        wait_req("t5", 10);
        rst_n = 1'b0;
        #1;
        check("t5r_req_valid",  bus.req_valid, 0);
        check("t5r_grant_ack",  bus.grant_ack, 0);
        check("t5r_rate_stall", rate_stall, 0);
        check("t5r_err",        err_spurious_grant, 0);
        check("t5r_tokens",     token_count, 0);
        check("t5r_level",      fifo_level, 0);
        check("t5r_pkt_ready",  bus.pkt_ready, 0);
        sb.delete();
        tok_m    = 0;
        cfg_rate = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t5r_ready_back", bus.pkt_ready, 1);
        check("t5r_no_ack", bus.grant_ack, 0);
        check("t5r_idle", bus.req_valid, 0);

        // ---- burst lowered under the current level; oversized head ----
        cfg_rate  = 10;
        cfg_burst = 100;
        for (int g = 0; g < 20 && tok_m < 80; g++) begin
            tick();
        end
        check("t6_tokens_80", token_count, 80);
        cfg_burst = 20;
        tick();
        check("t6_clamp", token_count, 20);
        push_desc(30, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t6_stall", rate_stall, 1);
            check("t6_no_req", bus.req_valid, 0);
            check("t6_tokens", token_count, tok_m);
            tick();
        end
        check("t6_tokens_capped", token_count, 20);
        check("t6_no_err", err_spurious_grant, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
